// File: rtl/async_fifo_sc.sv
// async_fifo_sc: single-clock circular-buffer FIFO that keeps the async_fifo port set.
// Write and read sides share wclk. Reset is asynchronous active-low.
// rdata is first-word fall-through. wfull and rempty are registered from the next-pointer values.
module async_fifo_sc #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty
);

    localparam int DEPTH = 1 << ASIZE;

    // Storage is never reset; a cleared pointer pair marks it as invalid.
    logic [DSIZE-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    logic [ASIZE:0]   wptr, rptr;
    logic [ASIZE:0]   wptr_next, rptr_next;
    logic             we, re;

    // Accept qualifiers: drop writes while full and reads while empty.
    always_comb begin
        we        = winc & ~wfull;
        re        = rinc & ~rempty;
        wptr_next = wptr + {{ASIZE{1'b0}}, we};
        rptr_next = rptr + {{ASIZE{1'b0}}, re};
    end

    // Memory write port; data only, so it takes no reset.
    always_ff @(posedge wclk) begin
        if (we) begin
            mem[wptr[ASIZE-1:0]] <= wdata;
        end
    end

    // Pointers and flags. The flags are computed from the next pointers so they are exact on the accepting edge.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
            wfull  <= 1'b0;
        end else begin
            wptr   <= wptr_next;
            rptr   <= rptr_next;
            rempty <= (wptr_next == rptr_next);
            wfull  <= (wptr_next[ASIZE] != rptr_next[ASIZE]) &&
                      (wptr_next[ASIZE-1:0] == rptr_next[ASIZE-1:0]);
        end
    end

    // Head-of-FIFO word. It is meaningful only while rempty is 0.
    assign rdata = mem[rptr[ASIZE-1:0]];

endmodule

// File: tb/tb_async_fifo_sc.sv
// Testbench for async_fifo_sc.
// A queue model is updated on every clock edge. A negedge monitor compares the flags and the head word against it.
// Directed literal checks pin the model at key points.
module tb_async_fifo_sc;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int DEPTH = 16;

    logic             wclk = 1'b0;
    logic             wrst_n = 1'b1;
    logic             winc = 1'b0;
    logic [DSIZE-1:0] wdata = '0;
    logic             rinc = 1'b0;
    logic [DSIZE-1:0] rdata;
    logic             wfull, rempty;

    int  n_total = 0;
    int  n_pass  = 0;
    bit  mon_en  = 1'b0;
    logic [7:0] q[$];

    async_fifo_sc #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .wclk  (wclk),
        .wrst_n(wrst_n),
        .winc  (winc),
        .wdata (wdata),
        .rinc  (rinc),
        .rdata (rdata),
        .wfull (wfull),
        .rempty(rempty)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy-based accept rules applied to a queue.
    bit m_wa, m_ra;
    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            q.delete();
        end else begin
            m_wa = (winc === 1'b1) && (q.size() < DEPTH);
            m_ra = (rinc === 1'b1) && (q.size() > 0);
            if (m_ra) void'(q.pop_front());
            if (m_wa) q.push_back(wdata);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge wclk) begin
        if (mon_en) begin
            chk("mon_rempty", 32'(rempty), 32'(q.size() == 0));
            chk("mon_wfull",  32'(wfull),  32'(q.size() == DEPTH));
            if (q.size() != 0) chk("mon_rdata", 32'(rdata), 32'(q[0]));
        end
    end

    // Drive one cycle of requests, then return 1 time unit after the edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        winc  = w;
        wdata = d;
        rinc  = r;
        @(posedge wclk);
        #1;
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (rempty !== 1'b0 ? 1'b0 : 1'b1) begin
            step(1'b0, 8'h00, 1'b1);
            guard++;
            if (guard > 40) begin
                chk("drain_timeout", 32'(guard), 32'(0));
                break;
            end
        end
    endtask

    initial begin
        #1 wrst_n = 1'b0;
        #1 mon_en = 1'b1;
        // Reset held for two cycles.
        repeat (2) @(posedge wclk);
        #1;
        chk("reset_rempty", 32'(rempty), 32'(1));
        chk("reset_wfull",  32'(wfull),  32'(0));
        wrst_n = 1'b1;

        // Reads while empty are dropped.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        chk("empty_read_rempty", 32'(rempty), 32'(1));

        // A single word.
        step(1'b1, 8'hA5, 1'b0);
        chk("single_rempty", 32'(rempty), 32'(0));
        chk("single_rdata",  32'(rdata),  32'(8'hA5));
        step(1'b0, 8'h00, 1'b1);
        chk("single_pop_rempty", 32'(rempty), 32'(1));

        // Fill and drain three times so the pointers wrap.
        for (int pass = 0; pass < 3; pass++) begin
            for (int i = 0; i < DEPTH; i++) begin
                step(1'b1, 8'(i), 1'b0);
                if (i == DEPTH - 2) chk("fill_not_full", 32'(wfull), 32'(0));
            end
            chk("fill_wfull", 32'(wfull), 32'(1));
            step(1'b1, 8'hFF, 1'b0);
            chk("overflow_wfull", 32'(wfull), 32'(1));
            for (int i = 0; i < DEPTH; i++) begin
                chk("fill_rdata", 32'(rdata), 32'(i));
                step(1'b0, 8'h00, 1'b1);
            end
            chk("fill_drained_rempty", 32'(rempty), 32'(1));
        end

        // Alternating traffic: writes on even cycles, reads every fourth cycle.
        for (int c = 0; c < 60; c++) begin
            step(c % 2 == 0, 8'($urandom_range(0, 255)), c % 4 == 2);
        end
        drain();
        chk("alt_drained_rempty", 32'(rempty), 32'(1));

        // Simultaneous write and read while full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        chk("sim_full_pre", 32'(wfull), 32'(1));
        step(1'b1, 8'hEE, 1'b1);
        chk("sim_full_wfull", 32'(wfull), 32'(0));
        chk("sim_full_rdata", 32'(rdata), 32'(8'h41));
        drain();

        // Simultaneous write and read while empty.
        chk("sim_empty_pre", 32'(rempty), 32'(1));
        step(1'b1, 8'h77, 1'b1);
        chk("sim_empty_rempty", 32'(rempty), 32'(0));
        chk("sim_empty_rdata",  32'(rdata),  32'(8'h77));
        drain();

        // Reset pulse in the middle of a stream.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h90 + i), 1'b0);
        chk("mid_pre_rempty", 32'(rempty), 32'(0));
        #2 wrst_n = 1'b0;
        #1;
        chk("mid_rst_rempty", 32'(rempty), 32'(1));
        chk("mid_rst_wfull",  32'(wfull),  32'(0));
        #3 wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        step(1'b1, 8'h3C, 1'b0);
        chk("mid_after_rdata", 32'(rdata), 32'(8'h3C));
        step(1'b0, 8'h00, 1'b1);
        chk("mid_after_rempty", 32'(rempty), 32'(1));

        @(posedge wclk);
        #1;
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
